// File: rtl/uart_prog_loader.sv
// UART-driven program/data loader: receives framed 8N1 bytes, assembles little-endian 32-bit words
// and issues one-cycle write strobes into the program ROM (adr[14]=0) or data memory (adr[14]=1).
module uart_prog_loader #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 128_000,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        upg_rx_i,
  output logic        upg_clk_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o,
  output logic        upg_tx_o
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {F_IDLE, F_HDR, F_DATA, F_DONE} f_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Receiver state
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_byte_valid, w_byte_valid_nxt;
  logic             r_rx_ferr, w_rx_ferr_nxt;

  // Frame state
  f_state_t         r_f_state, w_f_state_nxt;
  logic [1:0]       r_hdr_idx, w_hdr_idx_nxt;
  logic [1:0]       r_byte_idx, w_byte_idx_nxt;
  logic [31:0]      r_word, w_word_nxt;
  logic [15:0]      r_words_left, w_words_left_nxt;
  logic [14:0]      r_wr_adr, w_wr_adr_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
  logic             r_wen, w_wen_nxt;
  logic [14:0]      r_adr, w_adr_nxt;
  logic [31:0]      r_dat, w_dat_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             w_is_sync, w_tmo_hit;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_rx_cnt_nxt     = r_rx_cnt + 1'b1;
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_byte_valid_nxt = 1'b0;
    w_rx_ferr_nxt    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        // Re-check the line mid start bit so short low glitches are rejected.
        if (r_rx_cnt == CNT_W'(HALF - 1)) begin
          w_rx_cnt_nxt  = '0;
          w_bit_idx_nxt = '0;
          w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == CNT_W'(DIV - 1)) begin
          w_rx_cnt_nxt  = '0;
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == CNT_W'(DIV - 1)) begin
          w_rx_cnt_nxt     = '0;
          w_rx_state_nxt   = RX_IDLE;
          w_byte_valid_nxt = r_rx_sync;
          w_rx_ferr_nxt    = !r_rx_sync;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_f_state_nxt    = r_f_state;
    w_hdr_idx_nxt    = r_hdr_idx;
    w_byte_idx_nxt   = r_byte_idx;
    w_word_nxt       = r_word;
    w_words_left_nxt = r_words_left;
    w_wr_adr_nxt     = r_wr_adr;
    w_adr_nxt        = r_adr;
    w_dat_nxt        = r_dat;
    w_wen_nxt        = 1'b0;
    w_err_nxt        = 1'b0;
    w_tmo_nxt        = r_byte_valid ? '0 : r_tmo_cnt + 1'b1;
    w_is_sync        = r_byte_valid && (r_shift == SYNC_BYTE);
    w_tmo_hit        = ((r_f_state == F_HDR) || (r_f_state == F_DATA)) && !r_byte_valid &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    if (r_rx_ferr || w_tmo_hit) begin
      w_f_state_nxt = F_IDLE;
      w_err_nxt     = 1'b1;
    end else begin
      case (r_f_state)
        F_IDLE, F_DONE: begin
          if (w_is_sync) begin
            w_f_state_nxt = F_HDR;
            w_hdr_idx_nxt = '0;
          end
        end
        F_HDR: begin
          if (r_byte_valid) begin
            w_hdr_idx_nxt = r_hdr_idx + 2'd1;
            case (r_hdr_idx)
              2'd0: w_wr_adr_nxt[7:0]      = r_shift;
              2'd1: w_wr_adr_nxt[14:8]     = r_shift[6:0];
              2'd2: w_words_left_nxt[7:0]  = r_shift;
              default: begin
                w_words_left_nxt[15:8] = r_shift;
                w_byte_idx_nxt         = '0;
                w_f_state_nxt = ({r_shift, r_words_left[7:0]} == 16'd0) ? F_DONE : F_DATA;
              end
            endcase
          end
        end
        F_DATA: begin
          if (r_byte_valid) begin
            w_word_nxt[{r_byte_idx, 3'b000} +: 8] = r_shift;
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              w_wen_nxt        = 1'b1;
              w_adr_nxt        = r_wr_adr;
              w_dat_nxt        = {r_shift, r_word[23:0]};
              w_wr_adr_nxt     = r_wr_adr + 15'd1;
              w_words_left_nxt = r_words_left - 16'd1;
              if (r_words_left == 16'd1) w_f_state_nxt = F_DONE;
            end
          end
        end
        default: w_f_state_nxt = F_IDLE;
      endcase
    end
    // done rises one cycle after the last strobe and drops as soon as a new frame starts.
    w_done_nxt = (r_f_state == F_DONE) && (w_f_state_nxt == F_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_i) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_f_state    <= F_IDLE;
      r_hdr_idx    <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_words_left <= '0;
      r_wr_adr     <= '0;
      r_tmo_cnt    <= '0;
      r_wen        <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rx_meta    <= upg_rx_i;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_rx_state   <= w_rx_state_nxt;
      r_rx_cnt     <= w_rx_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_rx_ferr    <= w_rx_ferr_nxt;
      r_f_state    <= w_f_state_nxt;
      r_hdr_idx    <= w_hdr_idx_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_word       <= w_word_nxt;
      r_words_left <= w_words_left_nxt;
      r_wr_adr     <= w_wr_adr_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_wen        <= w_wen_nxt;
      r_adr        <= w_adr_nxt;
      r_dat        <= w_dat_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign upg_clk_o  = upg_clk_i;
  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = r_done;
  assign upg_err_o  = r_err;
  assign upg_tx_o   = 1'b1;

endmodule
